square_channel_ctrl: RTL and testbench
======================================

Name: square_channel_ctrl

Overview:
- Per-channel sequencer for the square-wave sound path. Drives the square generator's frequency, duty and enable inputs, and supplies a 4-bit volume to the mixer.
- Contains:
  - an internal 512 Hz-style frame sequencer;
  - a length counter;
  - a volume envelope;
  - a frequency-sweep unit (optional, see below).
- Register-write decode sits upstream and presents decoded fields plus one-cycle write/trigger pulses.

Parameters:
- CLKS_PER_STEP, 8192, I_CLK cycles per frame-sequencer step (4.194304 MHz / 512). Legal range 2..65535.

Ports:
- I_CLK  in  1  system clock
- I_RESET  in  1  synchronous, active-high reset
- I_TRIGGER  in  1  one-cycle pulse: (re)start channel
- I_LENGTH_LOAD  in  1  one-cycle pulse: load length counter from I_LENGTH
- I_LENGTH  in  6  length field; counter loads 64 - I_LENGTH
- I_LENGTH_EN  in  1  length counter stops channel when it expires
- I_ENV  in  8  [7:4] initial volume, [3] direction (1 = up), [2:0] period
- I_SWEEP  in  7  [6:4] period, [3] negate, [2:0] shift
- I_FREQ_WR  in  1  one-cycle pulse: I_FREQUENCY written
- I_FREQUENCY  in  11  frequency code
- I_DUTY  in  2  duty select, passed through
- O_FREQUENCY  out  11  frequency code to generator
- O_DUTY_CYCLE  out  2  duty to generator
- O_WAVEFORM_EN  out  1  channel active
- O_VOLUME  out  4  current envelope volume

Behaviour:
- Reset values (all registered):
  - O_FREQUENCY = 0, O_DUTY_CYCLE = 0, O_WAVEFORM_EN = 0, O_VOLUME = 0.
  - Internal: div = 0, step = 0, length_ctr = 0, env timer = 0, sweep timer = 0, shadow = 0, sweep_on = 0.
  - Reset overrides every other event in the same cycle.
- Frame sequencer:
  - div counts 0..CLKS_PER_STEP-1 and wraps.
  - On wrap, step_tick pulses for one cycle and step increments mod 8.
  - Runs continuously and is unaffected by trigger.
- Step actions, taken on the cycle step_tick is high, using the step value before increment:
  - length on steps 0, 2, 4, 6;
  - sweep on steps 2, 6;
  - envelope on step 7.
- Length:
  - I_LENGTH_LOAD sets length_ctr = 64 - I_LENGTH, so I_LENGTH = 0 gives 64; width is 7 bits.
  - On a length step with I_LENGTH_EN = 1 and length_ctr != 0: decrement. If the result is 0, clear O_WAVEFORM_EN on the next edge.
- Trigger (I_TRIGGER = 1):
  - O_WAVEFORM_EN = 1 unless the DAC is off (I_ENV[7:3] == 0), in which case it is 0.
  - length_ctr = 64 if currently 0.
  - O_VOLUME = I_ENV[7:4]; env timer = I_ENV[2:0].
  - shadow = O_FREQUENCY.
  - Sweep timer = I_SWEEP[6:4], with 0 loaded as 8.
  - sweep_on = (period != 0) | (shift != 0).
  - If shift != 0, run an overflow check: compute new = shadow ± (shadow >> shift) in 12 bits. If new > 2047, O_WAVEFORM_EN = 0.
- Envelope step, when I_ENV[2:0] != 0:
  - Decrement env timer.
  - On reaching 0: reload from I_ENV[2:0], then step O_VOLUME ±1, saturating at 0 and 15 (no wrap).
  - Period 0 means the envelope is frozen.
- Sweep step:
  - Decrement sweep timer. On reaching 0, reload it (0 → 8).
  - If sweep_on and period != 0, compute new:
    - if new > 2047: O_WAVEFORM_EN = 0;
    - else if shift != 0: shadow = new and O_FREQUENCY = new, then recompute from the new shadow; if the second result is > 2047, O_WAVEFORM_EN = 0.
  - Negate subtraction never underflows, because shadow >> shift ≤ shadow.
- Frequency: I_FREQ_WR loads O_FREQUENCY = I_FREQUENCY. If it coincides with a sweep write-back, the sweep write-back wins.
- Duty: O_DUTY_CYCLE <= I_DUTY every cycle.
- Simultaneous-event rules:
  - I_LENGTH_LOAD with I_TRIGGER: load first, then trigger, so a nonzero load is not replaced by 64.
  - I_TRIGGER with step_tick: trigger wins; that cycle's length/envelope/sweep actions are suppressed. The step counter still advances.
  - I_LENGTH_LOAD with a length step: the load wins; no decrement.
- Latency: every output reflects an event on the first I_CLK edge after it is sampled (1 cycle).
- No action reactivates the channel except I_TRIGGER.

Optional Feature:
- Macro: SQUARE_SWEEP_EN.
- Defined: sweep unit present as described above.
- Undefined:
  - no shadow register, sweep timer or overflow logic;
  - I_SWEEP is ignored;
  - O_FREQUENCY changes only via I_FREQ_WR;
  - trigger never disables the channel for overflow.
- This is for channel 2, which has no sweep.

Test Plan (CLKS_PER_STEP = 4):
- Reset, then trigger with I_ENV = 0xF0, I_LENGTH_LOAD of 62, I_LENGTH_EN = 1 → O_WAVEFORM_EN = 1 and O_VOLUME = 15 one cycle after trigger. Channel drops to 0 after the 2nd length step; O_VOLUME stays 15.
- I_ENV = 0x31 (vol 3, down, period 1), trigger → O_VOLUME goes 3, 2, 1, 0 on successive step-7 ticks (every 32 clocks), then holds at 0. With I_ENV = 0xE9 (vol 14, up) → 14, 15, 15.
- I_ENV = 0x00, trigger → O_WAVEFORM_EN stays 0.
- (SQUARE_SWEEP_EN) I_FREQUENCY = 0x400, I_SWEEP = 0x11 (period 1, add, shift 1), trigger → O_FREQUENCY = 0x600 after the first sweep step. The second check (0x900) exceeds 2047, so O_WAVEFORM_EN = 0.
- (SQUARE_SWEEP_EN) I_FREQUENCY = 0x7F0, I_SWEEP = 0x01, trigger → overflow at trigger; O_WAVEFORM_EN = 0 one cycle later.
- Trigger asserted on a step_tick cycle with length_ctr = 1 and I_LENGTH_EN = 1 → no decrement that cycle, channel stays active. Assert I_RESET mid-run → all outputs 0 on the next edge.

Source files
------------

// File: rtl/square_channel_ctrl.sv
// Square channel sequencer: frame sequencer, length, envelope, optional sweep (SQUARE_SWEEP_EN).
// All outputs registered, 1-cycle latency from sampled inputs; no backpressure.
module square_channel_ctrl #(
    parameter int CLKS_PER_STEP = 8192
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_TRIGGER,
    input  logic        I_LENGTH_LOAD,
    input  logic [5:0]  I_LENGTH,
    input  logic        I_LENGTH_EN,
    input  logic [7:0]  I_ENV,
    input  logic [6:0]  I_SWEEP,
    input  logic        I_FREQ_WR,
    input  logic [10:0] I_FREQUENCY,
    input  logic [1:0]  I_DUTY,
    output logic [10:0] O_FREQUENCY,
    output logic [1:0]  O_DUTY_CYCLE,
    output logic        O_WAVEFORM_EN,
    output logic [3:0]  O_VOLUME
);

    logic [15:0] r_div;
    logic [2:0]  r_step;
    logic [6:0]  r_length_ctr;
    logic [2:0]  r_env_timer;
    logic [10:0] r_freq;
    logic [1:0]  r_duty;
    logic        r_en;
    logic [3:0]  r_vol;

    logic        w_step_tick;
    logic        w_len_step;
    logic        w_sweep_step;
    logic        w_env_step;
    logic        w_dac_on;
    logic [6:0]  w_len_loaded;
    logic        w_len_expire;
    logic        w_trig_ovf;
    logic        w_sweep_ovf;
    logic        w_sweep_wb;
    logic [11:0] w_sweep_new;

    assign w_step_tick  = (r_div == 16'(CLKS_PER_STEP - 1));
    assign w_len_step   = w_step_tick & ~r_step[0];
    assign w_sweep_step = w_step_tick & (r_step[1:0] == 2'd2);
    assign w_env_step   = w_step_tick & (r_step == 3'd7);
    assign w_dac_on     = |I_ENV[7:3];
    assign w_len_loaded = 7'd64 - {1'b0, I_LENGTH};
    // Load and trigger both pre-empt the step decrement, so only a plain step can expire the counter.
    assign w_len_expire = w_len_step & I_LENGTH_EN & (r_length_ctr == 7'd1)
                        & ~I_LENGTH_LOAD & ~I_TRIGGER;

`ifdef SQUARE_SWEEP_EN
    logic [10:0] r_shadow;
    logic [3:0]  r_sweep_timer;
    logic        r_sweep_on;
    logic [11:0] w_trig_new;
    logic [11:0] w_sweep_new2;
    logic        w_sweep_fire;
    logic        w_sweep_act;
    logic        w_shift_nz;
    logic [3:0]  w_sweep_reload;
    logic [10:0] w_unused_new2;

    function automatic logic [11:0] sweep_calc(input logic [10:0] f, input logic [2:0] sh,
                                               input logic neg);
        logic [11:0] d;
        d = {1'b0, f} >> sh;
        return neg ? ({1'b0, f} - d) : ({1'b0, f} + d);
    endfunction

    assign w_shift_nz     = (I_SWEEP[2:0] != 3'd0);
    assign w_sweep_reload = (I_SWEEP[6:4] == 3'd0) ? 4'd8 : {1'b0, I_SWEEP[6:4]};
    assign w_trig_new     = sweep_calc(r_freq, I_SWEEP[2:0], I_SWEEP[3]);
    assign w_trig_ovf     = w_shift_nz & w_trig_new[11];
    assign w_sweep_new    = sweep_calc(r_shadow, I_SWEEP[2:0], I_SWEEP[3]);
    assign w_sweep_new2   = sweep_calc(w_sweep_new[10:0], I_SWEEP[2:0], I_SWEEP[3]);
    assign w_unused_new2  = w_sweep_new2[10:0];
    assign w_sweep_fire   = w_sweep_step & (r_sweep_timer <= 4'd1) & ~I_TRIGGER;
    assign w_sweep_act    = w_sweep_fire & r_sweep_on & (I_SWEEP[6:4] != 3'd0);
    assign w_sweep_ovf    = w_sweep_act & (w_sweep_new[11] | (w_shift_nz & w_sweep_new2[11]));
    assign w_sweep_wb     = w_sweep_act & ~w_sweep_new[11] & w_shift_nz;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_shadow      <= '0;
            r_sweep_timer <= '0;
            r_sweep_on    <= 1'b0;
        end else if (I_TRIGGER) begin
            r_shadow      <= r_freq;
            r_sweep_timer <= w_sweep_reload;
            r_sweep_on    <= (I_SWEEP[6:4] != 3'd0) | w_shift_nz;
        end else if (w_sweep_step) begin
            if (r_sweep_timer <= 4'd1) begin
                r_sweep_timer <= w_sweep_reload;
                if (w_sweep_wb)
                    r_shadow <= w_sweep_new[10:0];
            end else begin
                r_sweep_timer <= r_sweep_timer - 4'd1;
            end
        end
    end
`else
    logic w_unused_sweep;
    assign w_unused_sweep = ^{I_SWEEP, w_sweep_step};
    assign w_trig_ovf     = 1'b0;
    assign w_sweep_ovf    = 1'b0;
    assign w_sweep_wb     = 1'b0;
    assign w_sweep_new    = '0;
`endif

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_div        <= '0;
            r_step       <= '0;
            r_length_ctr <= '0;
            r_env_timer  <= '0;
            r_freq       <= '0;
            r_duty       <= '0;
            r_en         <= 1'b0;
            r_vol        <= '0;
        end else begin
            r_duty <= I_DUTY;

            if (w_step_tick) begin
                r_div  <= '0;
                r_step <= r_step + 3'd1;
            end else begin
                r_div <= r_div + 16'd1;
            end

            if (w_sweep_wb)
                r_freq <= w_sweep_new[10:0];
            else if (I_FREQ_WR)
                r_freq <= I_FREQUENCY;

            if (I_LENGTH_LOAD)
                r_length_ctr <= w_len_loaded;
            else if (I_TRIGGER) begin
                if (r_length_ctr == 7'd0)
                    r_length_ctr <= 7'd64;
            end else if (w_len_step && I_LENGTH_EN && r_length_ctr != 7'd0)
                r_length_ctr <= r_length_ctr - 7'd1;

            if (I_TRIGGER)
                r_en <= w_dac_on & ~w_trig_ovf;
            else if (w_len_expire || w_sweep_ovf)
                r_en <= 1'b0;

            if (I_TRIGGER) begin
                r_vol       <= I_ENV[7:4];
                r_env_timer <= I_ENV[2:0];
            end else if (w_env_step && I_ENV[2:0] != 3'd0) begin
                // A timer already at 0 (period changed mid-note) is treated as expired.
                if (r_env_timer <= 3'd1) begin
                    r_env_timer <= I_ENV[2:0];
                    if (I_ENV[3] && r_vol != 4'd15)
                        r_vol <= r_vol + 4'd1;
                    else if (!I_ENV[3] && r_vol != 4'd0)
                        r_vol <= r_vol - 4'd1;
                end else begin
                    r_env_timer <= r_env_timer - 3'd1;
                end
            end
        end
    end

    assign O_FREQUENCY   = r_freq;
    assign O_DUTY_CYCLE  = r_duty;
    assign O_WAVEFORM_EN = r_en;
    assign O_VOLUME      = r_vol;

endmodule

// File: tb/tb_square_channel_ctrl.sv
// Scoreboard bench for square_channel_ctrl with a 4-clock frame-sequencer step.
module tb_square_channel_ctrl;

    logic        clk = 1'b0;
    logic        I_RESET, I_TRIGGER, I_LENGTH_LOAD, I_LENGTH_EN, I_FREQ_WR;
    logic [5:0]  I_LENGTH;
    logic [7:0]  I_ENV;
    logic [6:0]  I_SWEEP;
    logic [10:0] I_FREQUENCY;
    logic [1:0]  I_DUTY;
    logic [10:0] O_FREQUENCY;
    logic [1:0]  O_DUTY_CYCLE;
    logic        O_WAVEFORM_EN;
    logic [3:0]  O_VOLUME;

    localparam int SEL_EN = 0, SEL_VOL = 1, SEL_FREQ = 2, SEL_DUTY = 3;

    typedef struct {
        int    at_edge;
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   ecnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    square_channel_ctrl #(.CLKS_PER_STEP(4)) dut (
        .I_CLK(clk), .I_RESET(I_RESET), .I_TRIGGER(I_TRIGGER),
        .I_LENGTH_LOAD(I_LENGTH_LOAD), .I_LENGTH(I_LENGTH), .I_LENGTH_EN(I_LENGTH_EN),
        .I_ENV(I_ENV), .I_SWEEP(I_SWEEP), .I_FREQ_WR(I_FREQ_WR), .I_FREQUENCY(I_FREQUENCY),
        .I_DUTY(I_DUTY), .O_FREQUENCY(O_FREQUENCY), .O_DUTY_CYCLE(O_DUTY_CYCLE),
        .O_WAVEFORM_EN(O_WAVEFORM_EN), .O_VOLUME(O_VOLUME)
    );

    always #5 clk = ~clk;

    // Edges counted since reset release; step actions land on edges that are multiples of 4.
    always @(posedge clk) begin
        if (I_RESET) ecnt <= 0;
        else         ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            SEL_EN:   return int'(O_WAVEFORM_EN);
            SEL_VOL:  return int'(O_VOLUME);
            SEL_FREQ: return int'(O_FREQUENCY);
            default:  return int'(O_DUTY_CYCLE);
        endcase
    endfunction

    task automatic expect_at(input int e, input string tag, input int sel, input int v);
        exp_t x;
        x.at_edge = e; x.tag = tag; x.sel = sel; x.exp = v;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0 && !I_RESET && sb[0].at_edge == ecnt) begin
            x = sb.pop_front();
            chk(x.tag, observe(x.sel), x.exp);
        end
    end

    task automatic goto(input int k);
        int g;
        g = 0;
        while (ecnt < k - 1 && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        if (ecnt != k - 1) chk("goto", ecnt, k - 1);
    endtask

    task automatic step1;
        @(posedge clk); #1;
        I_TRIGGER = 1'b0; I_LENGTH_LOAD = 1'b0; I_FREQ_WR = 1'b0;
    endtask

    task automatic drain;
        int g;
        g = 0;
        while (sb.size() != 0 && g < 2000) begin
            @(posedge clk);
            g++;
        end
        chk("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int sw;
`ifdef SQUARE_SWEEP_EN
        sw = 1;
`else
        sw = 0;
`endif
        I_RESET = 1'b1; I_TRIGGER = 1'b0; I_LENGTH_LOAD = 1'b0; I_LENGTH_EN = 1'b0;
        I_FREQ_WR = 1'b0; I_LENGTH = '0; I_ENV = '0; I_SWEEP = '0; I_FREQUENCY = '0;
        I_DUTY = 2'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", int'(O_WAVEFORM_EN), 0);
        chk("rst_vol", int'(O_VOLUME), 0);
        chk("rst_freq", int'(O_FREQUENCY), 0);
        chk("rst_duty", int'(O_DUTY_CYCLE), 0);
        @(posedge clk); #1;
        I_RESET = 1'b0;

        // Length expiry: load 62 -> counter 2, drops after the second length step (edge 12).
        expect_at(2, "len_en_on", SEL_EN, 1);
        expect_at(2, "len_vol", SEL_VOL, 15);
        expect_at(3, "duty", SEL_DUTY, 2);
        expect_at(11, "len_en_hold", SEL_EN, 1);
        expect_at(12, "len_expire", SEL_EN, 0);
        expect_at(40, "env_frozen", SEL_VOL, 15);
        goto(2);
        I_ENV = 8'hF0; I_LENGTH = 6'd62; I_LENGTH_EN = 1'b1;
        I_LENGTH_LOAD = 1'b1; I_TRIGGER = 1'b1;
        step1;

        // Envelope down from 3, one step per 32 clocks, saturating at 0.
        expect_at(42, "env_dn_init", SEL_VOL, 3);
        expect_at(42, "env_dn_en", SEL_EN, 1);
        expect_at(63, "env_dn_hold", SEL_VOL, 3);
        expect_at(64, "env_dn_2", SEL_VOL, 2);
        expect_at(95, "env_dn_hold2", SEL_VOL, 2);
        expect_at(96, "env_dn_1", SEL_VOL, 1);
        expect_at(128, "env_dn_0", SEL_VOL, 0);
        expect_at(161, "env_dn_sat", SEL_VOL, 0);
        goto(42);
        I_ENV = 8'h31; I_LENGTH_EN = 1'b0; I_TRIGGER = 1'b1;
        step1;

        // Envelope up from 14, saturating at 15.
        expect_at(170, "env_up_init", SEL_VOL, 14);
        expect_at(192, "env_up_15", SEL_VOL, 15);
        expect_at(224, "env_up_sat", SEL_VOL, 15);
        goto(170);
        I_ENV = 8'hE9; I_TRIGGER = 1'b1;
        step1;

        // DAC-off trigger disables; volume 0 with direction up keeps the DAC on.
        expect_at(229, "dac_pre", SEL_EN, 1);
        expect_at(230, "dac_off", SEL_EN, 0);
        expect_at(234, "dac_on_v0", SEL_EN, 1);
        goto(230);
        I_ENV = 8'h00; I_TRIGGER = 1'b1;
        step1;
        goto(234);
        I_ENV = 8'h08; I_TRIGGER = 1'b1;
        step1;

        // Load on a length step (236) and trigger on a length step (244) both block the decrement.
        expect_at(236, "load_on_step", SEL_EN, 1);
        expect_at(243, "ctr1_hold", SEL_EN, 1);
        expect_at(244, "trig_on_step", SEL_EN, 1);
        expect_at(246, "freq_wr", SEL_FREQ, 'h123);
        expect_at(251, "ctr1_hold2", SEL_EN, 1);
        expect_at(252, "ctr1_expire", SEL_EN, 0);
        goto(236);
        I_LENGTH = 6'd63; I_LENGTH_EN = 1'b1; I_LENGTH_LOAD = 1'b1;
        step1;
        goto(244);
        I_TRIGGER = 1'b1;
        step1;
        goto(246);
        I_FREQUENCY = 11'h123; I_FREQ_WR = 1'b1;
        step1;

        // Sweep: 0x400 -> 0x600 on the sweep step at edge 268, then the 0x900 check disables.
        expect_at(258, "sw_trig_en", SEL_EN, 1);
        expect_at(267, "sw_freq_pre", SEL_FREQ, 'h400);
        expect_at(268, "sw_freq", SEL_FREQ, sw ? 'h600 : 'h400);
        expect_at(268, "sw_ovf2", SEL_EN, sw ? 0 : 1);
        expect_at(273, "sw_freq_wr", SEL_FREQ, 'h7F0);
        expect_at(274, "sw_trig_ovf", SEL_EN, sw ? 0 : 1);
        goto(254);
        I_FREQUENCY = 11'h400; I_FREQ_WR = 1'b1;
        step1;
        goto(258);
        I_ENV = 8'hF0; I_SWEEP = 7'h11; I_LENGTH_EN = 1'b0; I_TRIGGER = 1'b1;
        step1;
        goto(272);
        I_FREQUENCY = 11'h7F0; I_FREQ_WR = 1'b1;
        step1;
        goto(274);
        I_SWEEP = 7'h01; I_TRIGGER = 1'b1;
        step1;
        drain;

        // Mid-run reset clears every output on the next edge.
        #1;
        I_RESET = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_en", int'(O_WAVEFORM_EN), 0);
        chk("mid_rst_vol", int'(O_VOLUME), 0);
        chk("mid_rst_freq", int'(O_FREQUENCY), 0);
        chk("mid_rst_duty", int'(O_DUTY_CYCLE), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
